// File: rtl/mmio_defs.sv
// Shared definitions for the MMIO slave: register offsets, UART state encoding
// and the byte-lane write merge used by every writable register.
package mmio_defs;

    localparam logic [15:0] OFF_LED         = 16'h0000;
    localparam logic [15:0] OFF_SWITCH      = 16'h0004;
    localparam logic [15:0] OFF_TIMER       = 16'h0008;
    localparam logic [15:0] OFF_SCRATCH     = 16'h000C;
    localparam logic [15:0] OFF_UART_DATA   = 16'h0010;
    localparam logic [15:0] OFF_UART_STATUS = 16'h0014;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // Lane i of the result comes from wdata when wen[i], else from old_val.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wen);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// Byte-serial 8N1 transmitter: one start bit, eight data bits LSB first, one
// stop bit, each CLK_DIV clocks long. A start pulse is only honoured when idle.
module uart_tx_8n1
    import mmio_defs::*;
#(
    parameter logic [15:0] CLK_DIV = 16'd868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy
);

    uart_state_e state, state_nxt;
    logic [15:0] baud_cnt, baud_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        baud_done;

    assign baud_done = (baud_cnt == CLK_DIV - 16'd1);

    // NOTE: async reset puts txd high at once through the state decode below,
    // so an aborted frame never leaves the line low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= UART_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shreg    <= shreg_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        txd       = 1'b1;
        busy      = 1'b1;
        unique case (state)
            UART_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = UART_START;
                    baud_nxt  = '0;
                    shreg_nxt = data;
                end
            end
            UART_START: begin
                txd = 1'b0;
                if (baud_done) begin
                    state_nxt = UART_DATA;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            UART_DATA: begin
                txd = shreg[0];
                if (baud_done) begin
                    baud_nxt  = '0;
                    shreg_nxt = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) state_nxt = UART_STOP;
                    else                 bit_nxt   = bit_idx + 3'd1;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            UART_STOP: begin
                if (baud_done) begin
                    state_nxt = UART_IDLE;
                    baud_nxt  = '0;
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            default: state_nxt = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/data_sram_mmio_slave.sv
// MMIO responder on the CPU data-side SRAM interface: LED, switches, timer,
// scratch and a UART transmitter behind a 64 KiB window selected by ADDR_HI.
module data_sram_mmio_slave
    import mmio_defs::*;
#(
    parameter logic [15:0] ADDR_HI = 16'hbfaf,
    parameter logic [15:0] CLK_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic        uart_txd
);

    logic        hit, rd_hit, wr_hit;
    logic [15:0] offset;
    logic [15:0] sw_meta, sw_sync;
    logic [31:0] timer, scratch;
    logic [31:0] led_merged, rd_mux;
    logic        uart_busy, uart_start;
    logic        unused_addr_bits;

    assign hit    = data_sram_en && (data_sram_addr[31:16] == ADDR_HI);
    assign rd_hit = hit && (data_sram_wen == 4'b0000);
    assign wr_hit = hit && (data_sram_wen != 4'b0000);
    assign offset = {data_sram_addr[15:2], 2'b00};
    assign unused_addr_bits = ^data_sram_addr[1:0];

    assign led_merged = merge_bytes({16'h0000, led_out}, data_sram_wdata, data_sram_wen);
    // Writes to a busy transmitter are dropped rather than queued.
    assign uart_start = wr_hit && (offset == OFF_UART_DATA) && data_sram_wen[0] && !uart_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switch_in;
            sw_sync <= sw_meta;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the timer read relies on this.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_out         <= 16'hffff;
            timer           <= '0;
            scratch         <= '0;
            data_sram_rdata <= '0;
        end else begin
            if (wr_hit && offset == OFF_LED) led_out <= led_merged[15:0];
            if (wr_hit && offset == OFF_TIMER)
                timer <= merge_bytes(timer, data_sram_wdata, data_sram_wen);
            else
                timer <= timer + 32'd1;
            if (wr_hit && offset == OFF_SCRATCH)
                scratch <= merge_bytes(scratch, data_sram_wdata, data_sram_wen);
            if (rd_hit) data_sram_rdata <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_LED:         rd_mux = {16'h0000, led_out};
            OFF_SWITCH:      rd_mux = {16'h0000, sw_sync};
            OFF_TIMER:       rd_mux = timer;
            OFF_SCRATCH:     rd_mux = scratch;
            OFF_UART_STATUS: rd_mux = {31'd0, uart_busy};
            default:         rd_mux = '0;
        endcase
    end

    uart_tx_8n1 #(
        .CLK_DIV (CLK_DIV)
    ) u_uart (
        .clk   (clk),
        .reset (reset),
        .start (uart_start),
        .data  (data_sram_wdata[7:0]),
        .txd   (uart_txd),
        .busy  (uart_busy)
    );

endmodule
